// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin arbiting multiplexer.
package mux_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Index width that stays at least one bit wide for tiny channel counts.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_mux_arb_pick.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set request.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N  = 32,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          win_vld
);

    logic hit_hi;

    always_comb begin
        win    = '0;
        hit_hi = 1'b0;
        // Descending scans leave the lowest matching index in win.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                win    = IW'(i);
                hit_hi = 1'b1;
            end
        end
        if (!hit_hi) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win = IW'(i);
                end
            end
        end
        win_vld = |req;
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-way round-robin arbiting multiplexer with single-entry valid/ready output stage
// and optional packet lock that holds the grant until the locked channel's last beat.
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter int NUM_CH     = 32,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MODE  = 0,
    parameter int IDX_WIDTH  = idx_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     req,
    input  logic [DATA_WIDTH-1:0] data_in [NUM_CH],
    input  logic [NUM_CH-1:0]     last_in,
    output logic [NUM_CH-1:0]     grant,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam bit LOCK_EN = (LOCK_MODE != 0);

    arb_state_e            state;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  lock_idx;
    logic [IDX_WIDTH-1:0]  pick_win;
    logic                  pick_vld;
    logic [IDX_WIDTH-1:0]  win;
    logic [IDX_WIDTH-1:0]  ptr_next;
    logic                  any_elig;
    logic                  win_last;
    logic                  load;

    rr_pick #(
        .N  (NUM_CH),
        .IW (IDX_WIDTH)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_vld (pick_vld)
    );

    // While locked only the locked channel is eligible; a dropped request just stalls.
    always_comb begin
        if (state == LOCK) begin
            win      = lock_idx;
            any_elig = req[lock_idx];
        end else begin
            win      = pick_win;
            any_elig = pick_vld;
        end
        win_last = last_in[win];
        load     = rst_n && any_elig && (!out_vld || out_rdy);
        ptr_next = (win == IDX_WIDTH'(NUM_CH - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        grant = '0;
        if (load) begin
            grant[win] = 1'b1;
        end
    end

    // Output stage: a new beat may replace a draining one in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            ptr      <= '0;
            lock_idx <= '0;
            out_vld  <= 1'b0;
            out_idx  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_idx  <= win;
            out_data <= data_in[win];
            out_last <= LOCK_EN ? win_last : 1'b0;
            if (state == ARB) begin
                if (LOCK_EN && !win_last) begin
                    state    <= LOCK;
                    lock_idx <= win;
                end else begin
                    ptr <= ptr_next;
                end
            end else if (win_last) begin
                state <= ARB;
                ptr   <= ptr_next;
            end
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: three instances (32-ch free-running, 8-ch packet lock, 5-ch non-pow2)
// with per-instance expected-beat queues drained by output monitors.
module tb_rr_mux_arb;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;

    logic [31:0] reqA, lastA, gA;
    logic [15:0] dA [32];
    logic [15:0] baseA;
    logic        rdyA, outA_vld, outA_last;
    logic [4:0]  outA_idx;
    logic [15:0] outA_data;

    logic [7:0]  reqB, lastB, gB;
    logic [15:0] dB [8];
    logic [15:0] baseB;
    logic        rdyB, outB_vld, outB_last;
    logic [2:0]  outB_idx;
    logic [15:0] outB_data;

    logic [4:0]  reqC, lastC, gC;
    logic [15:0] dC [5];
    logic [15:0] baseC;
    logic        rdyC, outC_vld, outC_last;
    logic [2:0]  outC_idx;
    logic [15:0] outC_data;

    beat_t qA[$];
    beat_t qB[$];
    beat_t qC[$];

    int checks = 0;
    int errors = 0;

    rr_mux_arb #(.NUM_CH(32), .DATA_WIDTH(16), .LOCK_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(reqA), .data_in(dA), .last_in(lastA), .grant(gA),
        .out_vld(outA_vld), .out_rdy(rdyA), .out_idx(outA_idx), .out_data(outA_data),
        .out_last(outA_last)
    );

    rr_mux_arb #(.NUM_CH(8), .DATA_WIDTH(16), .LOCK_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(reqB), .data_in(dB), .last_in(lastB), .grant(gB),
        .out_vld(outB_vld), .out_rdy(rdyB), .out_idx(outB_idx), .out_data(outB_data),
        .out_last(outB_last)
    );

    rr_mux_arb #(.NUM_CH(5), .DATA_WIDTH(16), .LOCK_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(reqC), .data_in(dC), .last_in(lastC), .grant(gC),
        .out_vld(outC_vld), .out_rdy(rdyC), .out_idx(outC_idx), .out_data(outC_data),
        .out_last(outC_last)
    );

    always_comb begin
        for (int i = 0; i < 32; i++) dA[i] = baseA + 16'(i);
        for (int i = 0; i < 8; i++)  dB[i] = baseB + 16'(i);
        for (int i = 0; i < 5; i++)  dC[i] = baseC + 16'(i);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input int idx, input logic [15:0] data, input logic last);
        beat_t b;
        b.idx  = idx;
        b.data = data;
        b.last = last;
        case (d)
            0:       qA.push_back(b);
            1:       qB.push_back(b);
            default: qC.push_back(b);
        endcase
    endtask

    // One cycle: check the grant vector at the falling edge, then advance past the rising edge.
    task automatic step(input int d, input logic [31:0] g);
        @(negedge clk);
        case (d)
            0:       chk("grantA", 64'(gA), 64'(g));
            1:       chk("grantB", 64'(gB), 64'(g));
            default: chk("grantC", 64'(gC), 64'(g));
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string nm, input int q_size, input beat_t e,
                            input int idx, input logic [15:0] data, input logic last);
        if (q_size == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected beat: got idx %0d expected none", nm, idx);
        end else begin
            chk({nm, "_idx"},  64'(idx),  64'(e.idx));
            chk({nm, "_data"}, 64'(data), 64'(e.data));
            chk({nm, "_last"}, 64'(last), 64'(e.last));
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        int    n;
        if (rst_n && outA_vld && rdyA) begin
            n = qA.size();
            if (n != 0) e = qA.pop_front();
            sb_check("sbA", n, e, int'(outA_idx), outA_data, outA_last);
        end
        if (rst_n && outB_vld && rdyB) begin
            n = qB.size();
            if (n != 0) e = qB.pop_front();
            sb_check("sbB", n, e, int'(outB_idx), outB_data, outB_last);
        end
        if (rst_n && outC_vld && rdyC) begin
            n = qC.size();
            if (n != 0) e = qC.pop_front();
            sb_check("sbC", n, e, int'(outC_idx), outC_data, outC_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        reqA = '1; lastA = '0; baseA = 16'h0; rdyA = 1'b1;
        reqB = '0; lastB = 8'b1111_0111; baseB = 16'h0; rdyB = 1'b1;
        reqC = '0; lastC = '0; baseC = 16'h0; rdyC = 1'b1;

        // Reset state, with requests asserted on A.
        #12;
        chk("rst_grantA", 64'(gA), 64'h0);
        chk("rst_vldA", 64'(outA_vld), 64'h0);
        chk("rst_idxA", 64'(outA_idx), 64'h0);
        chk("rst_dataA", 64'(outA_data), 64'h0);
        chk("rst_lastA", 64'(outA_last), 64'h0);
        chk("rst_vldB", 64'(outB_vld), 64'h0);
        chk("rst_vldC", 64'(outC_vld), 64'h0);
        reqA = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A: all channels requesting, full throughput round robin over 34 beats.
        reqA  = '1;
        baseA = 16'h1000;
        for (int k = 0; k < 34; k++) begin
            push(0, k % 32, 16'h1000 + 16'(k % 32), 1'b0);
            step(0, 32'd1 << (k % 32));
        end
        reqA = '0;

        // A: wrap from ch31 to ch0, then ch1 proves ptr ended at 1.
        reqA = 32'h4000_0000;
        push(0, 30, 16'h101E, 1'b0);
        step(0, 32'h4000_0000);
        reqA = 32'h8000_0001;
        push(0, 31, 16'h101F, 1'b0);
        step(0, 32'h8000_0000);
        push(0, 0, 16'h1000, 1'b0);
        step(0, 32'h0000_0001);
        reqA = 32'h8000_0003;
        push(0, 1, 16'h1001, 1'b0);
        step(0, 32'h0000_0002);

        // A: backpressure holds ch5 while inputs change underneath it.
        reqA  = 32'h0000_0020;
        baseA = 16'h2000;
        push(0, 5, 16'h2005, 1'b0);
        step(0, 32'h0000_0020);
        reqA  = '1;
        baseA = 16'h3000;
        rdyA  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_grantA", 64'(gA), 64'h0);
            chk("stall_vldA", 64'(outA_vld), 64'h1);
            chk("stall_idxA", 64'(outA_idx), 64'h5);
            chk("stall_dataA", 64'(outA_data), 64'h2005);
            @(posedge clk);
            #1;
        end
        rdyA = 1'b1;
        push(0, 6, 16'h3006, 1'b0);
        step(0, 32'h0000_0040);
        reqA = '0;
        step(0, 32'h0);
        step(0, 32'h0);

        // B: single-beat packet on ch1 moves ptr to 2.
        reqB  = 8'b0000_0010;
        baseB = 16'h4000;
        push(1, 1, 16'h4001, 1'b1);
        step(1, 32'h02);
        // B: ch3 locks, drops request for two cycles mid-packet, then finishes.
        reqB  = 8'b1000_1010;
        baseB = 16'h4100;
        push(1, 3, 16'h4103, 1'b0);
        step(1, 32'h08);
        baseB = 16'h4200;
        push(1, 3, 16'h4203, 1'b0);
        step(1, 32'h08);
        reqB  = 8'b1000_0010;
        baseB = 16'h4300;
        step(1, 32'h00);
        step(1, 32'h00);
        reqB     = 8'b1000_1010;
        lastB[3] = 1'b1;
        baseB    = 16'h4500;
        push(1, 3, 16'h4503, 1'b1);
        step(1, 32'h08);
        reqB  = 8'b1000_0010;
        baseB = 16'h4600;
        push(1, 7, 16'h4607, 1'b1);
        step(1, 32'h80);
        reqB  = 8'b0000_0010;
        baseB = 16'h4700;
        push(1, 1, 16'h4701, 1'b1);
        step(1, 32'h02);
        reqB = '0;
        step(1, 32'h00);
        step(1, 32'h00);

        // C: non-power-of-two channel count alternates ch0 and ch4.
        reqC  = 5'b10001;
        baseC = 16'h5000;
        for (int k = 0; k < 4; k++) begin
            push(2, (k % 2 == 0) ? 0 : 4, (k % 2 == 0) ? 16'h5000 : 16'h5004, 1'b0);
            step(2, (k % 2 == 0) ? 32'h01 : 32'h10);
        end
        reqC = '0;
        step(2, 32'h0);
        step(2, 32'h0);

        // B: async reset while locked on ch3 with a held beat; ch0 must win afterwards.
        reqB     = 8'b0000_1000;
        lastB[3] = 1'b0;
        rdyB     = 1'b0;
        baseB    = 16'h6000;
        step(1, 32'h08);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vldB", 64'(outB_vld), 64'h0);
        chk("arst_grantB", 64'(gB), 64'h0);
        chk("arst_idxB", 64'(outB_idx), 64'h0);
        reqB = 8'b0000_1001;
        rdyB = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grantB", 64'(gB), 64'h01);
        push(1, 0, 16'h6000, 1'b1);
        @(posedge clk);
        #1;
        reqB = '0;
        step(1, 32'h0);
        step(1, 32'h0);

        chk("qA_empty", 64'(qA.size()), 64'h0);
        chk("qB_empty", 64'(qB.size()), 64'h0);
        chk("qC_empty", 64'(qC.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
